// File: rtl/mips_pkg.sv
// Shared types and constants for the Mini-MIPS front end.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, VALID} fetch_state_t;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // Instruction field slices for j-type target and i-type immediate
  localparam int unsigned TARGET_MSB = 25;
  localparam int unsigned TARGET_LSB = 0;
  localparam int unsigned TARGET_W   = TARGET_MSB - TARGET_LSB + 1;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned IMM_W      = IMM_MSB - IMM_LSB + 1;

  // Sign-extended word offset of a branch immediate, in bytes
  function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for jr, j/jal, taken branch and sequential flow.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] rs_data,
  input  logic            jump,
  input  logic            jump_reg,
  input  logic            branch,
  input  logic            alu_zero,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] seq_pc;
  logic            unused_opcode;

  assign unused_opcode = ^inst[XLEN-1:TARGET_MSB+1];

  // jump_reg is only examined under jump so an undriven jump_reg never leaks through
  always_comb begin
    seq_pc  = pc + XLEN'(INST_BYTES);
    next_pc = seq_pc;
    if (jump) begin
      if (jump_reg) begin
        next_pc = {rs_data[XLEN-1:2], 2'b00};
      end else begin
        next_pc = {seq_pc[XLEN-1:TARGET_W+2], inst[TARGET_MSB:TARGET_LSB], 2'b00};
      end
    end else if (branch && alu_zero) begin
      next_pc = seq_pc + branch_offset(inst[IMM_MSB:IMM_LSB]);
    end
  end

  assign misaligned = jump && jump_reg && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// PC owner and instruction fetcher: req/ack word reads, holds the word until the core accepts it.
module fetch_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  input  logic            inst_accept,
  input  logic            jump,
  input  logic            jump_reg,
  input  logic            branch,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            addr_err
);

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  next_pc_calc u_next_pc_calc (
    .pc         (pc),
    .inst       (inst),
    .rs_data    (rs_data),
    .jump       (jump),
    .jump_reg   (jump_reg),
    .branch     (branch),
    .alu_zero   (alu_zero),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  // The request address is the PC register itself, so it is stable for the whole fetch
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      pc         <= RESET_PC;
      pc_plus4   <= RESET_PC + XLEN'(INST_BYTES);
      inst       <= '0;
      inst_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            state      <= VALID;
            imem_req   <= 1'b0;
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
          end
        end
        VALID: begin
          if (inst_accept) begin
            state      <= FETCH;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
            pc         <= next_pc;
            pc_plus4   <= next_pc + XLEN'(INST_BYTES);
            if (misaligned) begin
              addr_err <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a spec-level next-PC model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_accept;
  logic        jump;
  logic        jump_reg;
  logic        branch;
  logic        alu_zero;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;

  int          checks;
  int          failures;
  logic [31:0] exp_pc;
  logic [31:0] cur_inst;
  logic        exp_err;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_accept (inst_accept),
    .jump        (jump),
    .jump_reg    (jump_reg),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next PC written from the architectural rules with plain arithmetic
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                            input logic j, input logic jr, input logic br,
                                            input logic z, input logic [31:0] rs);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (j === 1'b1 && jr === 1'b1) return rs - (rs % 4);
    if (j === 1'b1) return (p4 & 32'hF000_0000) + ((w % (32'd1 << 26)) * 4);
    if (br === 1'b1 && z === 1'b1) begin
      off = int'(w % 65536);
      if (off >= 32768) off = off - 65536;
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  task automatic fetch(input logic [31:0] w, input int delay, input int nstray);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    check("imem_addr", imem_addr, exp_pc);
    // Stall: accept attempts while fetching must be ignored
    for (int i = 0; i < delay; i++) begin
      inst_accept = 1'b1;
      jump        = 1'b1;
      jump_reg    = 1'b1;
      rs_data     = $urandom;
      tick();
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, exp_pc);
      check("stall_valid", 32'(inst_valid), 32'd0);
    end
    inst_accept = 1'b0;
    jump        = 1'b0;
    jump_reg    = 1'b0;
    imem_ack    = 1'b1;
    imem_rdata  = w;
    tick();
    imem_ack    = 1'b0;
    imem_rdata  = $urandom;
    cur_inst    = w;
    check("inst_valid", 32'(inst_valid), 32'd1);
    check("inst", inst, w);
    check("req_drop", 32'(imem_req), 32'd0);
    check("pc", pc, exp_pc);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    for (int i = 0; i < nstray; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = ~w;
      tick();
      imem_ack   = 1'b0;
      check("stray_inst", inst, w);
      check("stray_valid", 32'(inst_valid), 32'd1);
      check("stray_req", 32'(imem_req), 32'd0);
    end
  endtask

  task automatic accept(input logic j, input logic jr, input logic br, input logic z,
                        input logic [31:0] rs);
    jump        = j;
    jump_reg    = jr;
    branch      = br;
    alu_zero    = z;
    rs_data     = rs;
    inst_accept = 1'b1;
    if (j === 1'b1 && jr === 1'b1 && (rs % 4) != 0) exp_err = 1'b1;
    exp_pc = ref_next(exp_pc, cur_inst, j, jr, br, z, rs);
    tick();
    inst_accept = 1'b0;
    jump        = 1'b0;
    jump_reg    = 1'bx;
    branch      = 1'b0;
    alu_zero    = 1'($urandom);
    check("acc_req", 32'(imem_req), 32'd1);
    check("acc_addr", imem_addr, exp_pc);
    check("acc_pc_plus4", pc_plus4, exp_pc + 32'd4);
    check("acc_valid", 32'(inst_valid), 32'd0);
    check("addr_err", 32'(addr_err), 32'(exp_err));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_pc      = 32'h0;
    exp_err     = 1'b0;
    cur_inst    = 32'h0;
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    inst_accept = 1'b0;
    jump        = 1'b0;
    jump_reg    = 1'b0;
    branch      = 1'b0;
    alu_zero    = 1'b0;
    rs_data     = 32'h0;

    tick();
    tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);
    check("rst_inst", inst, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);

    rst_n = 1'b1;
    check("idle_req", 32'(imem_req), 32'd0);
    tick();
    check("first_req", 32'(imem_req), 32'd1);

    // Sequential fetches at 0x0, 0x4, 0x8
    fetch($urandom, 2, 0);
    accept(1'b0, 1'bx, 1'b0, 1'b0, $urandom);
    fetch($urandom, 2, 0);
    accept(1'b0, 1'bx, 1'b0, 1'b0, $urandom);
    check("seq_addr_8", imem_addr, 32'h8);
    // Jump to 0x0040_0000; branch must be ignored under jump
    fetch(32'h0810_0000, 2, 0);
    accept(1'b1, 1'b0, 1'b1, 1'b1, $urandom);
    check("jump_400000", imem_addr, 32'h0040_0000);
    fetch(32'h0800_0010, 0, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    check("jump_40", imem_addr, 32'h0000_0040);
    fetch(32'h0800_0040, 1, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    check("jump_100", imem_addr, 32'h0000_0100);
    // Misaligned jr
    fetch(32'h0000_0008, 0, 0);
    check("err_before_jr", 32'(addr_err), 32'd0);
    accept(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0203);
    check("jr_200", imem_addr, 32'h0000_0200);
    check("jr_err", 32'(addr_err), 32'd1);
    fetch(32'h0800_0008, 0, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    check("jump_20", imem_addr, 32'h0000_0020);
    // beq with imm 0xFFFF, taken then not taken
    fetch(32'h1000_FFFF, 1, 0);
    accept(1'b0, 1'bx, 1'b1, 1'b1, $urandom);
    check("beq_taken", imem_addr, 32'h0000_0020);
    fetch(32'h1000_FFFF, 1, 0);
    accept(1'b0, 1'bx, 1'b1, 1'b0, $urandom);
    check("beq_not_taken", imem_addr, 32'h0000_0024);
    // Long stall with stray acks, then jr to the top of the address space
    fetch(32'h03E0_0008, 5, 3);
    accept(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    check("jr_top", imem_addr, 32'hFFFF_FFFC);
    fetch($urandom, 0, 1);
    check("top_pc_plus4", pc_plus4, 32'h0);
    accept(1'b0, 1'bx, 1'b0, 1'b0, $urandom);
    check("wrap_0", imem_addr, 32'h0);
    check("err_sticky", 32'(addr_err), 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      fetch($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      accept(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    end

    // Reset in the middle of a fetch
    check("pre_rst_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(imem_req), 32'd0);
    check("async_pc", pc, 32'h0);
    check("async_err", 32'(addr_err), 32'd0);
    exp_pc  = 32'h0;
    exp_err = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, 32'h0);
    fetch($urandom, 0, 0);
    accept(1'b0, 1'bx, 1'b0, 1'b0, $urandom);
    check("refetch_next", imem_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
